// File: rtl/pack_encoder.sv
// Entry stage of the pixel-pack pipeline: normalises sync polarity, generates x/y
// coordinates and qualifies pixels as valid only while the incoming timing is locked.
module pack_encoder #(
    parameter int H_ACT  = 1280,
    parameter int V_ACT  = 720,
    parameter int VS_POL = 1,
    parameter int HS_POL = 1,
    localparam int XW = $clog2(H_ACT),
    localparam int YW = $clog2(V_ACT),
    localparam int O_PACK_SIZE = 3*8 + 4 + XW + YW
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_vs,
    input  logic                   i_hs,
    input  logic                   i_de,
    input  logic [7:0]             i_r,
    input  logic [7:0]             i_g,
    input  logic [7:0]             i_b,
    output logic [O_PACK_SIZE-1:0] o_pack,
    output logic                   o_locked,
    output logic [7:0]             o_err_cnt
);

    // Line counter holds up to V_ACT+1 so an over-long frame stays distinguishable.
    localparam int              LW     = $clog2(V_ACT + 2);
    localparam logic [XW-1:0]   X_MAX  = XW'(H_ACT - 1);
    localparam logic [LW-1:0]   L_ACT  = LW'(V_ACT);
    localparam logic [LW-1:0]   L_SAT  = LW'(V_ACT + 1);
    localparam logic [LW-1:0]   L_YMAX = LW'(V_ACT - 1);
    localparam logic            VS_ACT = (VS_POL != 0);
    localparam logic            HS_ACT = (HS_POL != 0);

    typedef enum logic [1:0] {IDLE, CHECK, LOCK} state_t;

    logic          s1_vs, s1_hs, s1_de, s1_vs_d, s1_de_d;
    logic [7:0]    s1_r, s1_g, s1_b;

    logic [XW-1:0] x_q, x_nxt;
    logic          x_ovf, x_ovf_nxt;
    logic [LW-1:0] line_cnt, lines_done;
    logic          line_bad, bad_done;
    logic [YW-1:0] y_cur;

    state_t        state;
    logic [7:0]    err_cnt;

    logic [7:0]    p_r, p_g, p_b;
    logic          p_vs, p_hs, p_de;
    logic [XW-1:0] p_x;
    logic [YW-1:0] p_y;

    // Stage 1: capture inputs with syncs normalised to active-high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vs   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_de   <= 1'b0;
            s1_vs_d <= 1'b0;
            s1_de_d <= 1'b0;
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values; blocking
            // here would let s1_vs_d see this cycle's s1_vs and kill the edge detect.
            s1_vs   <= (i_vs == VS_ACT);
            s1_hs   <= (i_hs == HS_ACT);
            s1_de   <= i_de;
            s1_vs_d <= s1_vs;
            s1_de_d <= s1_de;
            s1_r    <= i_r;
            s1_g    <= i_g;
            s1_b    <= i_b;
        end
    end

    logic vs_edge, de_fall, line_start, x_at_max, line_ok, frame_ok, lose;

    assign vs_edge    = s1_vs & ~s1_vs_d;
    assign de_fall    = ~s1_de & s1_de_d;
    // A vs edge inside de restarts the pixel count: the remainder is line 0 of the new frame.
    assign line_start = s1_de & (~s1_de_d | vs_edge);
    assign x_at_max   = (x_q == X_MAX);
    assign line_ok    = x_at_max & ~x_ovf;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        x_nxt     = x_q;
        x_ovf_nxt = x_ovf;
        if (line_start) begin
            x_nxt     = '0;
            x_ovf_nxt = 1'b0;
        end else if (x_at_max) begin
            x_ovf_nxt = 1'b1;
        end else begin
            x_nxt = x_q + 1'b1;
        end
    end

    // Close the current line before the frame is judged when de falls on a vs edge.
    always_comb begin
        lines_done = line_cnt;
        bad_done   = line_bad;
        if (de_fall) begin
            if (line_cnt != L_SAT)
                lines_done = line_cnt + 1'b1;
            if (!line_ok)
                bad_done = 1'b1;
        end
    end

    assign frame_ok = (lines_done == L_ACT) & ~bad_done;
    assign lose     = (de_fall & ~line_ok) | (vs_edge & ~frame_ok);
    assign y_cur    = vs_edge ? '0 :
                      (line_cnt >= L_YMAX) ? YW'(L_YMAX) : YW'(line_cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q      <= '0;
            x_ovf    <= 1'b0;
            line_cnt <= '0;
            line_bad <= 1'b0;
        end else begin
            if (s1_de) begin
                x_q   <= x_nxt;
                x_ovf <= x_ovf_nxt;
            end
            if (vs_edge) begin
                line_cnt <= '0;
                line_bad <= 1'b0;
            end else begin
                line_cnt <= lines_done;
                line_bad <= bad_done;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE:  if (vs_edge) state <= CHECK;
                CHECK: if (vs_edge && frame_ok) state <= LOCK;
                LOCK: begin
                    if (lose) begin
                        state <= CHECK;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 2: output pack; coordinates are forced to zero outside de.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_r  <= '0;
            p_g  <= '0;
            p_b  <= '0;
            p_vs <= 1'b0;
            p_hs <= 1'b0;
            p_de <= 1'b0;
            p_x  <= '0;
            p_y  <= '0;
        end else begin
            p_r  <= s1_r;
            p_g  <= s1_g;
            p_b  <= s1_b;
            p_vs <= s1_vs;
            p_hs <= s1_hs;
            p_de <= s1_de;
            p_x  <= s1_de ? x_nxt : '0;
            p_y  <= s1_de ? y_cur : '0;
        end
    end

    assign o_locked  = (state == LOCK);
    assign o_err_cnt = err_cnt;
    assign o_pack    = {p_r, p_g, p_b, p_vs, p_hs, p_de, p_de & o_locked, p_x, p_y};

endmodule

// File: tb/tb_pack_encoder.sv
// Bench for pack_encoder at 8x4 timing: an active-high and an active-low sync instance
// run side by side against one frame-level reference model.
module tb_pack_encoder;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int XW    = $clog2(H_ACT);
    localparam int YW    = $clog2(V_ACT);
    localparam int PW    = 3*8 + 4 + XW + YW;
    localparam int VB    = XW + YW;
    localparam int DB    = XW + YW + 1;

    typedef struct packed {
        logic [PW-1:0] pack;
        logic          locked;
        logic [7:0]    err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_vs1, i_hs1, i_vs2, i_hs2, i_de;
    logic [7:0]    i_r, i_g, i_b;
    logic [PW-1:0] o_pack1, o_pack2;
    logic          o_locked1, o_locked2;
    logic [7:0]    o_err1, o_err2;

    pack_encoder #(.H_ACT(H_ACT), .V_ACT(V_ACT), .VS_POL(1), .HS_POL(1)) dut_pos (
        .clk(clk), .rstn(rstn), .i_vs(i_vs1), .i_hs(i_hs1), .i_de(i_de),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_pack(o_pack1), .o_locked(o_locked1), .o_err_cnt(o_err1)
    );

    pack_encoder #(.H_ACT(H_ACT), .V_ACT(V_ACT), .VS_POL(0), .HS_POL(0)) dut_neg (
        .clk(clk), .rstn(rstn), .i_vs(i_vs2), .i_hs(i_hs2), .i_de(i_de),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_pack(o_pack2), .o_locked(o_locked2), .o_err_cnt(o_err2)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;
    exp_t exp_q[$];
    exp_t cmp_e;

    int   n_valid, sum_x, sum_y, n_x7, n_y3;

    // Reference model: unbounded pixel/line counts judged against the frame rules.
    int m_prev_vs, m_prev_de, m_pix, m_lines, m_state, m_err;
    bit m_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void m_lose();
        m_state = 1;
        if (m_err < 255) m_err++;
    endfunction

    function automatic exp_t model_step(input bit vs, input bit hs, input bit de,
                                        input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        exp_t e;
        bit   vs_e, de_f, valid;
        int   x, y;
        vs_e = vs && !m_prev_vs;
        de_f = !de && m_prev_de;
        if (de_f) begin
            m_lines++;
            if (m_pix != H_ACT) begin
                m_bad = 1'b1;
                if (m_state == 2) m_lose();
            end
        end
        if (vs_e) begin
            if (m_state == 0)
                m_state = 1;
            else if (m_state == 1) begin
                if (m_lines == V_ACT && !m_bad) m_state = 2;
            end else if (m_lines != V_ACT || m_bad)
                m_lose();
            m_lines = 0;
            m_bad   = 1'b0;
        end
        x = 0;
        y = 0;
        if (de) begin
            if (!m_prev_de || vs_e) m_pix = 0;
            x = (m_pix < H_ACT) ? m_pix : H_ACT - 1;
            y = (m_lines < V_ACT) ? m_lines : V_ACT - 1;
            m_pix++;
        end
        valid    = de && (m_state == 2);
        e.pack   = {r, g, b, vs, hs, de, valid, x[XW-1:0], y[YW-1:0]};
        e.locked = (m_state == 2);
        e.err    = m_err[7:0];
        m_prev_vs = int'(vs);
        m_prev_de = int'(de);
        return e;
    endfunction

    task automatic model_reset();
        m_prev_vs = 0; m_prev_de = 0; m_pix = 0; m_lines = 0;
        m_state = 0; m_err = 0; m_bad = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic clr_stats();
        n_valid = 0; sum_x = 0; sum_y = 0; n_x7 = 0; n_y3 = 0;
    endtask

    // One pixel clock of stimulus; called just after a rising edge.
    task automatic step(input bit vs, input bit hs, input bit de);
        logic [7:0] r, g, b;
        r = 8'(cyc);
        g = 8'(cyc * 7 + 3);
        b = 8'(cyc) ^ 8'hA5;
        i_vs1 = vs;  i_hs1 = hs;
        i_vs2 = ~vs; i_hs2 = ~hs;
        i_de  = de;
        i_r = r; i_g = g; i_b = b;
        exp_q.push_back(model_step(vs, hs, de, r, g, b));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && exp_q.size() >= 3) begin
            cmp_e = exp_q.pop_front();
            check("pack_pos",   64'(o_pack1),   64'(cmp_e.pack));
            check("locked_pos", 64'(o_locked1), 64'(cmp_e.locked));
            check("err_pos",    64'(o_err1),    64'(cmp_e.err));
            check("pack_neg",   64'(o_pack2),   64'(cmp_e.pack));
            check("locked_neg", 64'(o_locked2), 64'(cmp_e.locked));
            check("err_neg",    64'(o_err2),    64'(cmp_e.err));
            if (o_pack1[VB]) begin
                n_valid++;
                sum_x += int'(o_pack1[XW+YW-1:YW]);
                sum_y += int'(o_pack1[YW-1:0]);
            end
            if (o_pack1[DB] && o_pack1[XW+YW-1:YW] == XW'(H_ACT - 1)) n_x7++;
            if (o_pack1[DB] && o_pack1[YW-1:0] == YW'(V_ACT - 1)) n_y3++;
        end
    end

    task automatic vsync();
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic line(input int len);
        step(0, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < len; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic frame_body(input int n_lines, input int bad_line, input int bad_len);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int l = 0; l < n_lines; l++) line((l == bad_line) ? bad_len : H_ACT);
        step(0, 0, 0);
    endtask

    task automatic frame(input int n_lines, input int bad_line, input int bad_len);
        vsync();
        frame_body(n_lines, bad_line, bad_len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pack_pos"},   64'(o_pack1),   64'd0);
        check({tag, "_locked_pos"}, 64'(o_locked1), 64'd0);
        check({tag, "_err_pos"},    64'(o_err1),    64'd0);
        check({tag, "_pack_neg"},   64'(o_pack2),   64'd0);
        check({tag, "_locked_neg"}, 64'(o_locked2), 64'd0);
        check({tag, "_err_neg"},    64'(o_err2),    64'd0);
    endtask

    // Asserts reset mid-cycle, confirms the asynchronous clear, then releases.
    task automatic do_reset();
        chk_en = 1'b0;
        rstn   = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        model_reset();
        rstn   = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        i_vs1 = 1'b0; i_hs1 = 1'b0; i_vs2 = 1'b1; i_hs2 = 1'b1; i_de = 1'b0;
        i_r = '0; i_g = '0; i_b = '0;
        clr_stats();
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rstn   = 1'b1;
        chk_en = 1'b1;

        // Clean frames: lock appears two clocks after the second vs edge.
        frame(4, -1, 0);
        check("lock_after_f1", 64'(o_locked1), 64'd0);
        step(1, 0, 0);
        check("lock_pre_rise", 64'(o_locked1), 64'd0);
        step(1, 0, 0);
        check("lock_rise", 64'(o_locked1), 64'd1);
        frame_body(4, -1, 0);
        clr_stats();
        frame(4, -1, 0);
        check("f3_valid_cnt", 64'(n_valid), 64'd32);
        check("f3_sum_x",     64'(sum_x),   64'd112);
        check("f3_sum_y",     64'(sum_y),   64'd48);
        check("f3_err",       64'(o_err1),  64'd0);

        // Short line while locked.
        frame(4, 2, 7);
        check("short_locked", 64'(o_locked1), 64'd0);
        check("short_err",    64'(o_err1),    64'd1);
        frame(4, -1, 0);
        frame(4, -1, 0);
        check("short_relock", 64'(o_locked1), 64'd1);

        // Long line: x saturates at H_ACT-1.
        clr_stats();
        frame(4, 1, 9);
        check("long_x7_cnt", 64'(n_x7),      64'd5);
        check("long_locked", 64'(o_locked1), 64'd0);
        check("long_err",    64'(o_err1),    64'd2);
        frame(4, -1, 0);
        frame(4, -1, 0);
        check("long_relock", 64'(o_locked1), 64'd1);

        // Five-line frame: y saturates, lock drops at the following vs edge.
        clr_stats();
        frame(5, -1, 0);
        check("tall_y3_cnt",    64'(n_y3),      64'd16);
        check("tall_still_lck", 64'(o_locked1), 64'd1);
        frame(4, -1, 0);
        check("tall_locked",    64'(o_locked1), 64'd0);
        check("tall_err",       64'(o_err1),    64'd3);
        frame(4, -1, 0);
        check("tall_relock",    64'(o_locked1), 64'd1);

        // Reset in the middle of a locked frame.
        vsync();
        step(0, 0, 0);
        step(0, 0, 0);
        line(H_ACT);
        step(0, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        line(H_ACT);
        line(H_ACT);
        step(0, 0, 0);
        check("rst_idle_lock", 64'(o_locked1), 64'd0);
        frame(4, -1, 0);
        check("rst_check_lock", 64'(o_locked1), 64'd0);
        frame(4, -1, 0);
        check("rst_relock",     64'(o_locked1), 64'd1);
        check("rst_err",        64'(o_err1),    64'd0);

        repeat (4) step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
